hazard_detection_unit: RTL and testbench
========================================

// Module: hazard_detection_unit
// PURPOSE
// Decode-stage hazard controller. Tracks destination registers of in-flight instructions
// in an internal EX/MEM/WB shadow pipeline and decides when ID must stall or be flushed.
// Drives the PC/IF-ID write enables and the ID/EX bubble.
// Exports ex_op_dest/mem_op_dest and hazard_en to the downstream forwarding unit.
// PARAMETERS
// REG_W      3   register-index width; index 0 is the hard-wired zero register
// CNT_W      16  width of the saturating stall-cycle counter
// PORTS
// clk           in   1      rising-edge clock
// rst           in   1      asynchronous, active-high reset
// fwd_en        in   1      1 = forwarding active; 0 = no forwarding, resolve RAW by stalling
// id_valid      in   1      ID holds a real instruction
// id_src1       in   REG_W  ID source register 1
// id_src2       in   REG_W  ID source register 2 (ALU operand or store data)
// id_src2_used  in   1      instruction reads id_src2
// id_dest       in   REG_W  ID destination register
// id_wb_en      in   1      ID instruction writes the register file
// id_is_load    in   1      ID instruction is a load
// br_taken      in   1      branch resolved taken in EX this cycle
// pc_write      out  1      1 = PC advances
// ifid_write    out  1      1 = IF/ID register loads
// ifid_flush    out  1      1 = IF/ID register clears
// idex_bubble   out  1      1 = ID/EX register loads a NOP
// hazard_en     out  1      1 = ID is stalled; forwarding unit suppresses selects
// ex_op_dest    out  REG_W  dest of instruction in EX; 0 if none or no write-back
// mem_op_dest   out  REG_W  dest of instruction in MEM; 0 if none or no write-back
// stall_cnt     out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
// - Reset (async, immediate): all shadow slots invalid, dests 0, stall_cnt 0.
//   Outputs during reset: pc_write=1, ifid_write=1, hazard_en=0, idex_bubble=0, ifid_flush=0.
// - Shadow slot = {dest, wb_en, is_load}. The slot dest reads as 0 when wb_en=0.
// - Match(s, slot) = id_valid & s!=0 & slot.wb_en & s==slot.dest. src2 counts only when id_src2_used.
// - stall (combinational, same cycle):
//   - fwd_en=1: Match on src1/src2 vs EX slot with EX.is_load=1. This is the load-use case and gives exactly 1 stall cycle.
//   - fwd_en=0: Match vs EX, MEM or WB slot. Gives up to 3 stall cycles; the register file writes on the clock edge.
// - Flush (br_taken=1) overrides stall in the same cycle.
//   - Drive ifid_flush=1, idex_bubble=1, pc_write=1, hazard_en=0.
// - Stall without flush: pc_write=0, ifid_write=0, idex_bubble=1, hazard_en=1.
// - Otherwise: pc_write=1, ifid_write=1, all other control outputs 0.
// - Clock edge:
//   - WB<=MEM and MEM<=EX, unconditionally.
//   - EX<=ID slot if id_valid & !stall & !br_taken, else EX<=empty.
// - stall_cnt increments on each edge where stall & !br_taken; holds at 2^CNT_W-1.
// - fwd_en may toggle any cycle; the new mode applies combinationally in that cycle.
// - A taken branch in the same cycle as a load-use stall: flush wins; no stall is counted.
// STRUCTURE
// - pipeline_pkg: REG_W, ZERO_REG=0, the slot struct {dest, wb_en, is_load}, FORWARD_EX_RES=2'b10, FORWARD_MEM_RES=2'b11.
// - Sub-module dest_shadow_stage: one slot register with async clear and load/bubble select. Instantiate it 3x for EX, MEM and WB.
// - Top level: comparators, stall/flush priority logic, saturating counter.
// TESTING
// - T1, load-use, fwd_en=1:
//   - Stimulus: ld r3, then add r1,r3,r2.
//   - Expect: 1 cycle of hazard_en=1, pc_write=0, idex_bubble=1; next cycle ex_op_dest=0, then add issues; stall_cnt=1.
// - T2, ALU RAW, fwd_en=0:
//   - Stimulus: add r3,... then sub r4,r3,r5.
//   - Expect: 3 stall cycles; ex/mem dest sequence 3,0 -> 0,3 -> 0,0; stall_cnt=3.
// - T3, zero register:
//   - Stimulus: ld r0, then use of r0, with fwd_en=0.
//   - Expect: no stall; stall also never asserts while id_valid=0.
// - T4, flush beats stall:
//   - Stimulus: br_taken=1 during a load-use stall.
//   - Expect: ifid_flush=1, pc_write=1, hazard_en=0, EX empty next cycle, stall_cnt unchanged.
// - T5, reset mid-stall:
//   - Stimulus: assert rst during a fwd_en=0 stall.
//   - Expect: outputs go to their reset values immediately; after release, a sub r4,r3,r5 issues with no stall.
// - T6, saturation:
//   - Stimulus: preload/force stall_cnt to 0xFFFE, then 3 stall cycles.
//   - Expect: stall_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-index width, shadow-slot layout and the
// source-vs-slot match rule used by the hazard detection logic.
package pipeline_pkg;

   localparam int unsigned REG_W = 3;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   // Forwarding-mux select codes consumed by the downstream forwarding unit
   localparam logic [1:0] FORWARD_EX_RES  = 2'b10;
   localparam logic [1:0] FORWARD_MEM_RES = 2'b11;

   typedef struct packed {
      logic [REG_W-1:0] dest;
      logic             wb_en;
      logic             is_load;
   } slot_t;

   function automatic logic src_match(input logic             valid,
                                      input logic [REG_W-1:0] src,
                                      input slot_t            slot);
      return valid && (src != ZERO_REG) && slot.wb_en && (src == slot.dest);
   endfunction

endpackage

// File: rtl/dest_shadow_stage.sv
// One shadow-pipeline slot: loads the incoming slot or a bubble on each clock edge,
// cleared asynchronously by reset.
module dest_shadow_stage
   import pipeline_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  load_i,
   input  slot_t slot_i,
   output slot_t slot_o
);

   slot_t slot_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_q <= '0;
      end else begin
         slot_q <= load_i ? slot_i : '0;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard controller: tracks in-flight destinations in an EX/MEM/WB shadow
// pipeline and produces stall/flush controls plus a saturating stall-cycle counter.
module hazard_detection_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             fwd_en_i,
   input  logic             id_valid_i,
   input  logic [REG_W-1:0] id_src1_i,
   input  logic [REG_W-1:0] id_src2_i,
   input  logic             id_src2_used_i,
   input  logic [REG_W-1:0] id_dest_i,
   input  logic             id_wb_en_i,
   input  logic             id_is_load_i,
   input  logic             br_taken_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             hazard_en_o,
   output logic [REG_W-1:0] ex_op_dest_o,
   output logic [REG_W-1:0] mem_op_dest_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   slot_t id_slot, ex_slot, mem_slot, wb_slot;
   logic  hit_ex, hit_mem, hit_wb;
   logic  stall, count_en, ex_load;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Dest is zeroed for non-writing instructions so the exported dests read 0
   assign id_slot.dest    = id_wb_en_i ? id_dest_i : ZERO_REG;
   assign id_slot.wb_en   = id_wb_en_i;
   assign id_slot.is_load = id_is_load_i;

   assign hit_ex  = src_match(id_valid_i, id_src1_i, ex_slot) |
                    (id_src2_used_i & src_match(id_valid_i, id_src2_i, ex_slot));
   assign hit_mem = src_match(id_valid_i, id_src1_i, mem_slot) |
                    (id_src2_used_i & src_match(id_valid_i, id_src2_i, mem_slot));
   assign hit_wb  = src_match(id_valid_i, id_src1_i, wb_slot) |
                    (id_src2_used_i & src_match(id_valid_i, id_src2_i, wb_slot));

   // With forwarding only load-use needs a bubble; without it any in-flight writer does
   assign stall    = fwd_en_i ? (hit_ex & ex_slot.is_load) : (hit_ex | hit_mem | hit_wb);
   assign count_en = stall & ~br_taken_i;
   assign ex_load  = id_valid_i & ~stall & ~br_taken_i;

   dest_shadow_stage u_ex_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (ex_load),
      .slot_i (id_slot),
      .slot_o (ex_slot)
   );

   dest_shadow_stage u_mem_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (1'b1),
      .slot_i (ex_slot),
      .slot_o (mem_slot)
   );

   dest_shadow_stage u_wb_stage (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (1'b1),
      .slot_i (mem_slot),
      .slot_o (wb_slot)
   );

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      hazard_en_o   = 1'b0;
      if (!rst_i) begin
         if (br_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
         end else if (stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            hazard_en_o   = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (count_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_op_dest_o  = ex_slot.dest;
   assign mem_op_dest_o = mem_slot.dest;
   assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit: directed hazard scenarios then random traffic,
// with expected outputs from an in-flight history model; a narrow-counter copy checks saturation.
module tb_hazard_detection_unit;

   typedef struct packed {
      logic       v;
      logic [2:0] s1;
      logic [2:0] s2;
      logic       s2u;
      logic [2:0] d;
      logic       wb;
      logic       ld;
   } instr_t;

   typedef struct packed {
      logic        pcw, ifw, fl, bub, hz;
      logic [2:0]  exd, memd;
      logic [15:0] cnt;
      logic [1:0]  cnts;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fwd_en = 1'b0, id_valid = 1'b0, id_src2_used = 1'b0, id_wb_en = 1'b0;
   logic id_is_load = 1'b0, br_taken = 1'b0;
   logic [2:0] id_src1 = '0, id_src2 = '0, id_dest = '0;

   logic        pcw, ifw, fl, bub, hz;
   logic [2:0]  exd, memd;
   logic [15:0] cnt;
   logic        pcw_s, ifw_s, fl_s, bub_s, hz_s;
   logic [2:0]  exd_s, memd_s;
   logic [1:0]  cnt_s;

   always #5 clk = ~clk;

   hazard_detection_unit #(.CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .fwd_en_i(fwd_en), .id_valid_i(id_valid),
      .id_src1_i(id_src1), .id_src2_i(id_src2), .id_src2_used_i(id_src2_used),
      .id_dest_i(id_dest), .id_wb_en_i(id_wb_en), .id_is_load_i(id_is_load),
      .br_taken_i(br_taken), .pc_write_o(pcw), .ifid_write_o(ifw), .ifid_flush_o(fl),
      .idex_bubble_o(bub), .hazard_en_o(hz), .ex_op_dest_o(exd), .mem_op_dest_o(memd),
      .stall_cnt_o(cnt)
   );

   hazard_detection_unit #(.CNT_W(2)) dut_sat (
      .clk_i(clk), .rst_i(rst), .fwd_en_i(fwd_en), .id_valid_i(id_valid),
      .id_src1_i(id_src1), .id_src2_i(id_src2), .id_src2_used_i(id_src2_used),
      .id_dest_i(id_dest), .id_wb_en_i(id_wb_en), .id_is_load_i(id_is_load),
      .br_taken_i(br_taken), .pc_write_o(pcw_s), .ifid_write_o(ifw_s), .ifid_flush_o(fl_s),
      .idex_bubble_o(bub_s), .hazard_en_o(hz_s), .ex_op_dest_o(exd_s), .mem_op_dest_o(memd_s),
      .stall_cnt_o(cnt_s)
   );

   exp_t   exp_q[$];
   string  name_q[$];
   int     checks = 0;
   int     passed = 0;

   // Model: hist[a] is the instruction that entered EX a+1 edges ago (v=0 for a bubble)
   instr_t      hist[3];
   int unsigned mcnt = 0;
   int unsigned mcnts = 0;

   function automatic instr_t mk(input logic v, input int d, input int s1, input int s2,
                                 input logic s2u, input logic wb, input logic ld);
      instr_t i;
      i.v = v; i.d = 3'(d); i.s1 = 3'(s1); i.s2 = 3'(s2);
      i.s2u = s2u; i.wb = wb; i.ld = ld;
      return i;
   endfunction

   function automatic logic model_stall(input instr_t id, input logic fwd);
      logic hit;
      if (!id.v) return 1'b0;
      for (int a = 0; a < 3; a++) begin
         if (hist[a].v && hist[a].wb && hist[a].d != 3'd0) begin
            hit = (id.s1 == hist[a].d) || (id.s2u && id.s2 == hist[a].d);
            if (hit && (fwd ? (a == 0 && hist[a].ld) : 1'b1)) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [2:0] dest_of(input instr_t h);
      return (h.v && h.wb) ? h.d : 3'd0;
   endfunction

   task automatic cycle(input instr_t id, input logic fwd, input logic br, input string name,
                        output logic stalled);
      exp_t e;
      id_valid = id.v; id_src1 = id.s1; id_src2 = id.s2; id_src2_used = id.s2u;
      id_dest = id.d; id_wb_en = id.wb; id_is_load = id.ld;
      fwd_en = fwd; br_taken = br;
      stalled = !rst && model_stall(id, fwd);
      e = '0;
      if (rst) begin
         e.pcw = 1'b1; e.ifw = 1'b1;
      end else begin
         e.fl   = br;
         e.bub  = br | stalled;
         e.pcw  = br | !stalled;
         e.ifw  = br | !stalled;
         e.hz   = stalled & !br;
         e.exd  = dest_of(hist[0]);
         e.memd = dest_of(hist[1]);
         e.cnt  = 16'(mcnt);
         e.cnts = 2'(mcnts);
      end
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge clk);
      if (rst) begin
         hist[0] = '0; hist[1] = '0; hist[2] = '0;
         mcnt = 0; mcnts = 0;
      end else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = (id.v && !stalled && !br) ? id : '0;
         if (stalled && !br) begin
            if (mcnt < 65535) mcnt++;
            if (mcnts < 3) mcnts++;
         end
      end
      #1;
   endtask

   // Hold the instruction in ID until it issues, as the real IF/ID register would
   task automatic issue(input instr_t id, input logic fwd, input string name);
      logic st;
      int   n = 0;
      do begin
         cycle(id, fwd, 1'b0, name, st);
         n++;
      end while (st && n < 8);
      if (st) begin
         checks++;
         $display("FAIL %s issue_timeout: still stalled after %0d cycles, required issue", name, n);
      end
   endtask

   task automatic do_reset();
      logic st;
      rst = 1'b1;
      cycle(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, "reset", st);
      rst = 1'b0;
   endtask

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got == req) passed++;
      else $display("FAIL %s: got %0d required %0d", name, got, req);
   endtask

   // Monitor: outputs are presented every cycle; compare at the falling edge
   always @(negedge clk) begin
      exp_t  e, g, gs, es;
      string nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         g  = '{pcw, ifw, fl, bub, hz, exd, memd, cnt, e.cnts};
         checks++;
         if (g == e) passed++;
         else $display("FAIL %s main: got pcw=%b ifw=%b fl=%b bub=%b hz=%b ex=%0d mem=%0d cnt=%0d required pcw=%b ifw=%b fl=%b bub=%b hz=%b ex=%0d mem=%0d cnt=%0d",
                       nm, g.pcw, g.ifw, g.fl, g.bub, g.hz, g.exd, g.memd, g.cnt,
                       e.pcw, e.ifw, e.fl, e.bub, e.hz, e.exd, e.memd, e.cnt);
         gs = '{pcw_s, ifw_s, fl_s, bub_s, hz_s, exd_s, memd_s, 16'd0, cnt_s};
         es = e;
         es.cnt = 16'd0;
         checks++;
         if (gs == es) passed++;
         else $display("FAIL %s sat: got hz=%b ex=%0d mem=%0d cnt=%0d required hz=%b ex=%0d mem=%0d cnt=%0d",
                       nm, gs.hz, gs.exd, gs.memd, gs.cnts, es.hz, es.exd, es.memd, es.cnts);
      end
   end

   initial begin
      logic   st;
      instr_t cur;
      logic   fwd;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      @(posedge clk);
      #1;

      // T1 load-use with forwarding: ld r3 ; add r1,r3,r2
      do_reset();
      issue(mk(1, 3, 1, 0, 0, 1, 1), 1'b1, "t1_ld");
      issue(mk(1, 1, 3, 2, 1, 1, 0), 1'b1, "t1_add");
      cycle(mk(0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, "t1_idle", st);
      chk("t1_stall_cnt", int'(cnt), 1);

      // T2 ALU RAW without forwarding: add r3 ; sub r4,r3,r5
      do_reset();
      issue(mk(1, 3, 1, 2, 1, 1, 0), 1'b0, "t2_add");
      issue(mk(1, 4, 3, 5, 1, 1, 0), 1'b0, "t2_sub");
      chk("t2_stall_cnt", int'(cnt), 3);

      // T3 zero register never hazards; invalid ID never stalls
      do_reset();
      issue(mk(1, 0, 1, 0, 0, 1, 1), 1'b0, "t3_ld_r0");
      issue(mk(1, 2, 0, 0, 1, 1, 0), 1'b0, "t3_use_r0");
      issue(mk(1, 3, 1, 0, 0, 1, 1), 1'b0, "t3_ld_r3");
      for (int i = 0; i < 3; i++) cycle(mk(0, 4, 3, 3, 1, 1, 0), 1'b0, 1'b0, "t3_invalid", st);
      chk("t3_stall_cnt", int'(cnt), 0);

      // T4 taken branch during a load-use stall
      do_reset();
      issue(mk(1, 3, 1, 0, 0, 1, 1), 1'b1, "t4_ld");
      cycle(mk(1, 1, 3, 2, 1, 1, 0), 1'b1, 1'b1, "t4_flush", st);
      cycle(mk(0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, "t4_after", st);
      chk("t4_stall_cnt", int'(cnt), 0);

      // T5 reset asserted mid-stall
      do_reset();
      issue(mk(1, 3, 1, 2, 1, 1, 0), 1'b0, "t5_add");
      cycle(mk(1, 4, 3, 5, 1, 1, 0), 1'b0, 1'b0, "t5_stall", st);
      rst = 1'b1;
      cycle(mk(1, 4, 3, 5, 1, 1, 0), 1'b0, 1'b0, "t5_in_reset", st);
      rst = 1'b0;
      issue(mk(1, 4, 3, 5, 1, 1, 0), 1'b0, "t5_sub");
      chk("t5_stall_cnt", int'(cnt), 0);

      // T6 saturation: 6 stalls against a 2-bit counter copy
      do_reset();
      for (int k = 0; k < 2; k++) begin
         issue(mk(1, 3, 1, 2, 1, 1, 0), 1'b0, "t6_add");
         issue(mk(1, 4, 3, 5, 1, 1, 0), 1'b0, "t6_sub");
      end
      chk("t6_cnt_wide", int'(cnt), 6);
      chk("t6_cnt_sat", int'(cnt_s), 3);

      // Random traffic; stalled instructions stay in ID, flushed ones are replaced
      do_reset();
      fwd = 1'b1;
      cur = mk(0, 0, 0, 0, 0, 0, 0);
      st  = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic br;
         if ($urandom_range(0, 15) == 0) fwd = ~fwd;
         br = ($urandom_range(0, 7) == 0);
         if (!st) begin
            cur = mk($urandom_range(0, 9) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
         end
         cycle(cur, fwd, br, "random", st);
         if (br) st = 1'b0;
      end

      @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
